// File: rtl/video_pattern_gen.sv
// Test-pattern source for the hdmi core: five patterns, debounced button advance, 1-cycle rgb latency.
// Defining VIDEO_PATTERN_AUTO_CYCLE_EN adds auto-advance every FRAMES_PER_PATTERN frames.
module video_pattern_gen #(
  parameter int unsigned BIT_WIDTH          = 10,
  parameter int unsigned BOX_SIZE           = 32,
  parameter int unsigned BOX_STEP           = 2,
  parameter int unsigned CHECK_SHIFT        = 5,
  parameter int unsigned DEBOUNCE_CYCLES    = 250000,
  parameter int unsigned FRAMES_PER_PATTERN = 300
) (
  input  logic                 clk_pixel,
  input  logic                 reset,
  input  logic                 btn_next,
  input  logic [BIT_WIDTH-1:0] cx,
  input  logic [BIT_WIDTH-1:0] cy,
  input  logic [BIT_WIDTH-1:0] screen_start_x,
  input  logic [BIT_WIDTH-1:0] screen_start_y,
  input  logic [BIT_WIDTH-1:0] screen_width,
  input  logic [BIT_WIDTH-1:0] screen_height,
  output logic [23:0]          rgb,
  output logic [2:0]           pattern_id,
  output logic                 frame_tick
);
  localparam int unsigned BW  = BIT_WIDTH;
  localparam int unsigned DBW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [BW:0]    BOX_W   = (BW+1)'(BOX_SIZE);
  localparam logic [BW:0]    STEP_W  = (BW+1)'(BOX_STEP);

  // Returns {direction, position} of one box axis after a frame step.
  function automatic logic [BW:0] box_axis(input logic [BW-1:0] pos, input logic dir,
                                           input logic [BW-1:0] extent);
    logic [BW:0] lim, p, nxt;
    logic        nd;
    lim = ({1'b0, extent} > BOX_W) ? ({1'b0, extent} - BOX_W) : '0;
    p   = {1'b0, pos};
    nd  = dir;
    if (dir) begin
      if (p + STEP_W > lim) begin
        nd  = 1'b0;
        nxt = (p >= STEP_W) ? p - STEP_W : '0;
      end else begin
        nxt = p + STEP_W;
      end
    end else begin
      if (p < STEP_W) begin
        nd  = 1'b1;
        nxt = p + STEP_W;
      end else begin
        nxt = p - STEP_W;
      end
    end
    if (nxt > lim) nxt = lim;
    return {nd, nxt[BW-1:0]};
  endfunction

  logic [1:0]    sync_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic          db_q, db_d, pending_q, pending_d;
  logic [2:0]    pattern_q, pattern_d;
  logic          frame_tick_q, tick_now, advance, auto_adv;
  logic [BW-1:0] bx_q, bx_d, by_q, by_d, sub_q, sub_d;
  logic          dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic [BW:0]   ax_n, ay_n;
  logic [2:0]    bar_q, bar_d;
  logic [23:0]   rgb_q, rgb_d, bar_rgb;
  logic [BW-1:0] x, y, bar_w;
  logic [8:0]    sum9;
  logic          active, in_box;

  assign tick_now = (cx == '0) && (cy == '0);
  assign advance  = tick_now && (pending_q || auto_adv);

`ifdef VIDEO_PATTERN_AUTO_CYCLE_EN
  localparam int unsigned FCW = (FRAMES_PER_PATTERN > 1) ? $clog2(FRAMES_PER_PATTERN) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_PATTERN - 1);
  logic [FCW-1:0] fc_q, fc_d;

  assign auto_adv = tick_now && (fc_q == FC_LAST);

  always_comb begin
    fc_d = fc_q;
    if (tick_now) fc_d = advance ? '0 : fc_q + 1'b1;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) fc_q <= '0;
    else       fc_q <= fc_d;
  end
`else
  assign auto_adv = 1'b0;
`endif

  // Button: level accepted only after DEBOUNCE_CYCLES consecutive differing samples.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = '0;
    if (sync_q[1] != db_q) begin
      if (db_cnt_q == DB_LAST) db_d = sync_q[1];
      else                     db_cnt_d = db_cnt_q + 1'b1;
    end
    pending_d = (pending_q && !tick_now) || (db_d && !db_q);
    pattern_d = pattern_q;
    if (advance) pattern_d = (pattern_q == 3'd4) ? 3'd0 : pattern_q + 3'd1;
  end

  // Box moves on every frame start regardless of the displayed pattern.
  always_comb begin
    ax_n    = box_axis(bx_q, dir_x_q, screen_width);
    ay_n    = box_axis(by_q, dir_y_q, screen_height);
    bx_d    = tick_now ? ax_n[BW-1:0] : bx_q;
    dir_x_d = tick_now ? ax_n[BW]     : dir_x_q;
    by_d    = tick_now ? ay_n[BW-1:0] : by_q;
    dir_y_d = tick_now ? ay_n[BW]     : dir_y_q;
  end

  always_comb begin
    x      = cx - screen_start_x;
    y      = cy - screen_start_y;
    active = (cx >= screen_start_x) && (cy >= screen_start_y);
    sum9   = x[8:0] + y[8:0];
    bar_w  = {3'b000, screen_width[BW-1:3]};
    in_box = ({1'b0, x} >= {1'b0, bx_d}) && ({1'b0, x} < {1'b0, bx_d} + BOX_W) &&
             ({1'b0, y} >= {1'b0, by_d}) && ({1'b0, y} < {1'b0, by_d} + BOX_W);
    // Bar index tracked by a run-length counter instead of dividing x by the bar width.
    sub_d = '0;
    bar_d = '0;
    if (x != '0) begin
      if (sub_q + 1'b1 >= bar_w) begin
        bar_d = (bar_q == 3'd7) ? 3'd7 : bar_q + 3'd1;
      end else begin
        sub_d = sub_q + 1'b1;
        bar_d = bar_q;
      end
    end
    case (bar_d)
      3'd0:    bar_rgb = 24'hFFFFFF;
      3'd1:    bar_rgb = 24'hFFFF00;
      3'd2:    bar_rgb = 24'h00FFFF;
      3'd3:    bar_rgb = 24'h00FF00;
      3'd4:    bar_rgb = 24'hFF00FF;
      3'd5:    bar_rgb = 24'hFF0000;
      3'd6:    bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    rgb_d = 24'h000000;
    if (active) begin
      case (pattern_d)
        3'd0: begin
          if (x == '0)      rgb_d = 24'hFF0000;
          else if (y == '0) rgb_d = 24'h00FF00;
          else if ((x == screen_width - 1'b1) || (y == screen_height - 1'b1))
                            rgb_d = 24'h0000FF;
        end
        3'd1: rgb_d = bar_rgb;
        3'd2: rgb_d = {x[7:0], y[7:0], sum9[8:1]};
        3'd3: rgb_d = (x[CHECK_SHIFT] ^ y[CHECK_SHIFT]) ? 24'hFFFFFF : 24'h000000;
        3'd4: rgb_d = in_box ? 24'hFFFFFF : 24'h000040;
        default: rgb_d = 24'h000000;
      endcase
    end
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      sync_q       <= 2'b00;
      db_cnt_q     <= '0;
      db_q         <= 1'b0;
      pending_q    <= 1'b0;
      pattern_q    <= 3'd0;
      frame_tick_q <= 1'b0;
      bx_q         <= '0;
      by_q         <= '0;
      dir_x_q      <= 1'b1;
      dir_y_q      <= 1'b1;
      sub_q        <= '0;
      bar_q        <= 3'd0;
      rgb_q        <= 24'h000000;
    end else begin
      sync_q       <= {sync_q[0], btn_next};
      db_cnt_q     <= db_cnt_d;
      db_q         <= db_d;
      pending_q    <= pending_d;
      pattern_q    <= pattern_d;
      frame_tick_q <= tick_now;
      bx_q         <= bx_d;
      by_q         <= by_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      sub_q        <= sub_d;
      bar_q        <= bar_d;
      rgb_q        <= rgb_d;
    end
  end

  assign rgb        = rgb_q;
  assign pattern_id = pattern_q;
  assign frame_tick = frame_tick_q;
endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a 640x480 raster starting at 160/45.
module tb_video_pattern_gen;
  logic        clk_pixel = 1'b0;
  logic        reset, btn_next;
  logic [9:0]  cx, cy, ssx, ssy, sw, sh;
  logic [23:0] rgb;
  logic [2:0]  pattern_id;
  logic        frame_tick;
  logic [23:0] r, exp_rgb;
  int          checks = 0;
  int          failures = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  video_pattern_gen #(.DEBOUNCE_CYCLES(4), .FRAMES_PER_PATTERN(3)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .btn_next(btn_next),
    .cx(cx), .cy(cy), .screen_start_x(ssx), .screen_start_y(ssy),
    .screen_width(sw), .screen_height(sh),
    .rgb(rgb), .pattern_id(pattern_id), .frame_tick(frame_tick)
  );

  always #5 clk_pixel = ~clk_pixel;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    reset = 1'b1; btn_next = 1'b0; cx = 10'd1; cy = 10'd1;
    @(posedge clk_pixel); @(posedge clk_pixel); #1;
    reset = 1'b0;
  endtask

  task automatic tick();
    cx = 10'd0; cy = 10'd0;
    @(posedge clk_pixel); #1;
    cx = 10'd1; cy = 10'd1;
  endtask

  task automatic press(input int n);
    btn_next = 1'b1;
    repeat (n) @(posedge clk_pixel);
    #1 btn_next = 1'b0;
    repeat (12) @(posedge clk_pixel);
    #1;
  endtask

  task automatic pix(input int x, input int y, output logic [23:0] o);
    cx = 10'(x + 160); cy = 10'(y + 45);
    @(posedge clk_pixel); #1;
    o = rgb;
    cx = 10'd1; cy = 10'd1;
  endtask

  task automatic test_reset();
    do_reset();
    press(10); tick();
    checks++; if (pattern_id !== 3'd1) begin failures++; $display("FAIL pre_reset_pattern got=%0d exp=1", pattern_id); end
    cx = 10'd460; cy = 10'd245;
    @(posedge clk_pixel); #3;
    reset = 1'b1; #1;
    checks++; if (rgb !== 24'h0) begin failures++; $display("FAIL reset_rgb got=%h exp=000000", rgb); end
    checks++; if (pattern_id !== 3'd0) begin failures++; $display("FAIL reset_pattern got=%0d exp=0", pattern_id); end
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", frame_tick); end
    @(posedge clk_pixel); #1 reset = 1'b0;
    pix(0, 0, r);
    checks++; if (r !== 24'hFF0000) begin failures++; $display("FAIL first_pixel got=%h exp=FF0000", r); end
    pix(5, 0, r);
    checks++; if (r !== 24'h00FF00) begin failures++; $display("FAIL border_top got=%h exp=00FF00", r); end
    pix(639, 10, r);
    checks++; if (r !== 24'h0000FF) begin failures++; $display("FAIL border_right got=%h exp=0000FF", r); end
    pix(10, 479, r);
    checks++; if (r !== 24'h0000FF) begin failures++; $display("FAIL border_bottom got=%h exp=0000FF", r); end
    pix(10, 10, r);
    checks++; if (r !== 24'h000000) begin failures++; $display("FAIL border_inside got=%h exp=000000", r); end
    pix(-1, 10, r);
    checks++; if (r !== 24'h000000) begin failures++; $display("FAIL border_inactive got=%h exp=000000", r); end
  endtask

  task automatic test_bars();
    do_reset();
    press(10); tick();
    checks++; if (pattern_id !== 3'd1) begin failures++; $display("FAIL bars_pattern got=%0d exp=1", pattern_id); end
    for (int c = 0; c < 800; c++) begin
      cx = 10'(c); cy = 10'd100;
      @(posedge clk_pixel); #1;
      exp_rgb = (c < 160) ? 24'h0 : bars[(c - 160) / 80];
      checks++; if (rgb !== exp_rgb) begin failures++; $display("FAIL bars cx=%0d got=%h exp=%h", c, rgb, exp_rgb); end
    end
    cx = 10'd300; cy = 10'd10;
    @(posedge clk_pixel); #1;
    checks++; if (rgb !== 24'h0) begin failures++; $display("FAIL bars_inactive_row got=%h exp=000000", rgb); end
    cx = 10'd1; cy = 10'd1;
  endtask

  task automatic test_button();
    do_reset();
    press(3); tick();
    checks++; if (pattern_id !== 3'd0) begin failures++; $display("FAIL short_pulse got=%0d exp=0", pattern_id); end
    press(10); press(10);
    checks++; if (pattern_id !== 3'd0) begin failures++; $display("FAIL before_tick got=%0d exp=0", pattern_id); end
    tick();
    checks++; if (frame_tick !== 1'b1) begin failures++; $display("FAIL tick_pulse got=%b exp=1", frame_tick); end
    checks++; if (pattern_id !== 3'd1) begin failures++; $display("FAIL two_presses got=%0d exp=1", pattern_id); end
    @(posedge clk_pixel); #1;
    checks++; if (frame_tick !== 1'b0) begin failures++; $display("FAIL tick_one_cycle got=%b exp=0", frame_tick); end
    tick();
    checks++; if (pattern_id !== 3'd1) begin failures++; $display("FAIL collapsed got=%0d exp=1", pattern_id); end
  endtask

  task automatic test_gradient_checker();
    do_reset();
    press(10); tick(); press(10); tick();
    checks++; if (pattern_id !== 3'd2) begin failures++; $display("FAIL grad_pattern got=%0d exp=2", pattern_id); end
    pix(300, 200, r);
    checks++; if (r !== 24'h2CC8FA) begin failures++; $display("FAIL grad_300_200 got=%h exp=2CC8FA", r); end
    pix(255, 255, r);
    checks++; if (r !== 24'hFFFFFF) begin failures++; $display("FAIL grad_255_255 got=%h exp=FFFFFF", r); end
    pix(256, 1, r);
    checks++; if (r !== 24'h000180) begin failures++; $display("FAIL grad_256_1 got=%h exp=000180", r); end
    press(10); tick();
    checks++; if (pattern_id !== 3'd3) begin failures++; $display("FAIL chk_pattern got=%0d exp=3", pattern_id); end
    pix(0, 0, r);
    checks++; if (r !== 24'h000000) begin failures++; $display("FAIL chk_0_0 got=%h exp=000000", r); end
    pix(32, 0, r);
    checks++; if (r !== 24'hFFFFFF) begin failures++; $display("FAIL chk_32_0 got=%h exp=FFFFFF", r); end
    pix(32, 32, r);
    checks++; if (r !== 24'h000000) begin failures++; $display("FAIL chk_32_32 got=%h exp=000000", r); end
    pix(63, 31, r);
    checks++; if (r !== 24'hFFFFFF) begin failures++; $display("FAIL chk_63_31 got=%h exp=FFFFFF", r); end
    pix(64, 0, r);
    checks++; if (r !== 24'h000000) begin failures++; $display("FAIL chk_64_0 got=%h exp=000000", r); end
  endtask

  task automatic test_box();
    do_reset();
    repeat (4) begin press(10); tick(); end
    checks++; if (pattern_id !== 3'd4) begin failures++; $display("FAIL box_pattern got=%0d exp=4", pattern_id); end
    // 4 ticks since reset: bx = by = 8
    pix(7, 8, r);
    checks++; if (r !== 24'h000040) begin failures++; $display("FAIL box4_left_out got=%h exp=000040", r); end
    pix(8, 8, r);
    checks++; if (r !== 24'hFFFFFF) begin failures++; $display("FAIL box4_left_in got=%h exp=FFFFFF", r); end
    pix(39, 39, r);
    checks++; if (r !== 24'hFFFFFF) begin failures++; $display("FAIL box4_far_in got=%h exp=FFFFFF", r); end
    pix(40, 8, r);
    checks++; if (r !== 24'h000040) begin failures++; $display("FAIL box4_right_out got=%h exp=000040", r); end
    pix(8, 7, r);
    checks++; if (r !== 24'h000040) begin failures++; $display("FAIL box4_top_out got=%h exp=000040", r); end
    // 304 ticks: bx = 608 (limit), by bounced at 448 on tick 225 -> 288
    repeat (300) tick();
    pix(608, 288, r);
    checks++; if (r !== 24'hFFFFFF) begin failures++; $display("FAIL box304_in got=%h exp=FFFFFF", r); end
    pix(607, 288, r);
    checks++; if (r !== 24'h000040) begin failures++; $display("FAIL box304_out got=%h exp=000040", r); end
    pix(639, 319, r);
    checks++; if (r !== 24'hFFFFFF) begin failures++; $display("FAIL box304_corner got=%h exp=FFFFFF", r); end
    // 305 ticks: x bounces to 606, y continues down to 286
    tick();
    pix(606, 286, r);
    checks++; if (r !== 24'hFFFFFF) begin failures++; $display("FAIL box305_in got=%h exp=FFFFFF", r); end
    pix(605, 286, r);
    checks++; if (r !== 24'h000040) begin failures++; $display("FAIL box305_left got=%h exp=000040", r); end
    pix(637, 317, r);
    checks++; if (r !== 24'hFFFFFF) begin failures++; $display("FAIL box305_corner got=%h exp=FFFFFF", r); end
    pix(638, 286, r);
    checks++; if (r !== 24'h000040) begin failures++; $display("FAIL box305_right got=%h exp=000040", r); end
    pix(606, 318, r);
    checks++; if (r !== 24'h000040) begin failures++; $display("FAIL box305_bottom got=%h exp=000040", r); end
  endtask

  task automatic test_auto_cycle();
    do_reset();
`ifdef VIDEO_PATTERN_AUTO_CYCLE_EN
    for (int t = 1; t <= 15; t++) begin
      tick();
      checks++; if (pattern_id !== 3'((t / 3) % 5)) begin failures++; $display("FAIL auto tick=%0d got=%0d exp=%0d", t, pattern_id, (t / 3) % 5); end
    end
    do_reset();
    tick(); tick(); press(10); tick();
    checks++; if (pattern_id !== 3'd1) begin failures++; $display("FAIL auto_and_btn got=%0d exp=1", pattern_id); end
    tick(); tick();
    checks++; if (pattern_id !== 3'd1) begin failures++; $display("FAIL auto_cleared got=%0d exp=1", pattern_id); end
    tick();
    checks++; if (pattern_id !== 3'd2) begin failures++; $display("FAIL auto_after_clear got=%0d exp=2", pattern_id); end
`else
    for (int t = 1; t <= 7; t++) begin
      tick();
      checks++; if (pattern_id !== 3'd0) begin failures++; $display("FAIL no_auto tick=%0d got=%0d exp=0", t, pattern_id); end
    end
`endif
  endtask

  initial begin
    reset = 1'b1; btn_next = 1'b0; cx = 10'd1; cy = 10'd1;
    ssx = 10'd160; ssy = 10'd45; sw = 10'd640; sh = 10'd480;
    test_reset();
    test_bars();
    test_button();
    test_gradient_checker();
    test_box();
    test_auto_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
